// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU decode constants: control-word layout (DEC*), ALU
//               operations (ALU*), access sizes (SZ*), branch conditions (COND*).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Single-bit flags occupy the low bits of the decoded control word
    localparam int DECINVALID = 0;
    localparam int DECBRANCH  = 1;
    localparam int DECLINK    = 2;
    localparam int DECSETRD   = 3;
    localparam int DECSETRT   = 4;
    localparam int DECSETFT   = 5;
    localparam int DECREGFT   = 6;
    localparam int DECLOAD    = 7;
    localparam int DECSTORE   = 8;
    localparam int DECNFLAG   = 9;

    localparam int DECALULSB  = 9;
    localparam int DECALUW    = 4;
    localparam int DECSZLSB   = 13;
    localparam int DECSZW     = 2;
    localparam int DECCONDLSB = 15;
    localparam int DECCONDW   = 3;
    localparam int DECTGTLSB  = 18;
    localparam int DECTGTW    = 5;
    localparam int DECMAX     = DECTGTLSB + DECTGTW - 1;

    localparam logic [DECALUW-1:0] ALUNOP  = 4'd0;
    localparam logic [DECALUW-1:0] ALUADD  = 4'd1;
    localparam logic [DECALUW-1:0] ALUSUB  = 4'd2;
    localparam logic [DECALUW-1:0] ALUAND  = 4'd3;
    localparam logic [DECALUW-1:0] ALUOR   = 4'd4;
    localparam logic [DECALUW-1:0] ALUXOR  = 4'd5;
    localparam logic [DECALUW-1:0] ALUNOR  = 4'd6;
    localparam logic [DECALUW-1:0] ALUSLT  = 4'd7;
    localparam logic [DECALUW-1:0] ALUSLTU = 4'd8;
    localparam logic [DECALUW-1:0] ALUSLL  = 4'd9;
    localparam logic [DECALUW-1:0] ALUSRL  = 4'd10;
    localparam logic [DECALUW-1:0] ALUSRA  = 4'd11;
    localparam logic [DECALUW-1:0] ALULUI  = 4'd12;

    localparam logic [DECSZW-1:0] SZB = 2'd0;
    localparam logic [DECSZW-1:0] SZH = 2'd1;
    localparam logic [DECSZW-1:0] SZW = 2'd2;
    localparam logic [DECSZW-1:0] SZD = 2'd3;

    localparam logic [DECCONDW-1:0] CONDNONE = 3'd0;
    localparam logic [DECCONDW-1:0] CONDEQ   = 3'd1;
    localparam logic [DECCONDW-1:0] CONDNE   = 3'd2;
    localparam logic [DECCONDW-1:0] CONDLEZ  = 3'd3;
    localparam logic [DECCONDW-1:0] CONDGTZ  = 3'd4;
    localparam logic [DECCONDW-1:0] CONDLTZ  = 3'd5;
    localparam logic [DECCONDW-1:0] CONDGEZ  = 3'd6;
    localparam logic [DECCONDW-1:0] CONDALW  = 3'd7;

    typedef logic [DECMAX:0] dec_t;

    // Destination register: rd beats rt beats link ($31); otherwise none
    function automatic logic [DECTGTW-1:0] dec_target(
        input logic [DECNFLAG-1:0] fl,
        input logic [4:0]          rd,
        input logic [4:0]          rt
    );
        if (fl[DECSETRD])     return rd;
        else if (fl[DECSETRT]) return rt;
        else if (fl[DECLINK])  return 5'd31;
        else                   return 5'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idec_lane.sv
`default_nettype none
// ============================================================================
// Module      : idec_lane
// Description : Combinational instruction decoder producing the control word.
//               FPU loads/stores decoded only when IDEC_QUEUE_FPU_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module idec_lane
    import cpu_pkg::*;
(
    input  logic [31:0]  instr_i,
    output logic [DECMAX:0] dec_o
);

    logic [5:0]          op;
    logic [5:0]          funct;
    logic [DECNFLAG-1:0] fl;
    logic [DECALUW-1:0]  alu;
    logic [DECSZW-1:0]   sz;
    logic [DECCONDW-1:0] cond;
    logic                unused_fields;

    assign op            = instr_i[31:26];
    assign funct         = instr_i[5:0];
    assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

    always_comb begin
        fl   = '0;
        alu  = ALUNOP;
        sz   = SZB;
        cond = CONDNONE;
        case (op)
            6'h00: begin
                fl[DECSETRD] = 1'b1;
                case (funct)
                    6'h20, 6'h21: alu = ALUADD;
                    6'h22, 6'h23: alu = ALUSUB;
                    6'h24:        alu = ALUAND;
                    6'h25:        alu = ALUOR;
                    6'h26:        alu = ALUXOR;
                    6'h27:        alu = ALUNOR;
                    6'h2A:        alu = ALUSLT;
                    6'h2B:        alu = ALUSLTU;
                    6'h00:        alu = ALUSLL;
                    6'h02:        alu = ALUSRL;
                    6'h03:        alu = ALUSRA;
                    6'h08: begin
                        fl            = '0;
                        fl[DECBRANCH] = 1'b1;
                        cond          = CONDALW;
                    end
                    6'h09: begin
                        fl[DECBRANCH] = 1'b1;
                        cond          = CONDALW;
                    end
                    default: begin
                        fl             = '0;
                        fl[DECINVALID] = 1'b1;
                    end
                endcase
            end
            6'h01: begin
                // REGIMM: only BLTZ/BGEZ are recognised
                if (instr_i[20:17] == 4'd0) begin
                    fl[DECBRANCH] = 1'b1;
                    cond          = instr_i[16] ? CONDGEZ : CONDLTZ;
                end else begin
                    fl[DECINVALID] = 1'b1;
                end
            end
            6'h02: begin fl[DECBRANCH] = 1'b1; cond = CONDALW; end
            6'h03: begin fl[DECBRANCH] = 1'b1; fl[DECLINK] = 1'b1; cond = CONDALW; end
            6'h04: begin fl[DECBRANCH] = 1'b1; alu = ALUSUB; cond = CONDEQ;  end
            6'h05: begin fl[DECBRANCH] = 1'b1; alu = ALUSUB; cond = CONDNE;  end
            6'h06: begin fl[DECBRANCH] = 1'b1; alu = ALUSUB; cond = CONDLEZ; end
            6'h07: begin fl[DECBRANCH] = 1'b1; alu = ALUSUB; cond = CONDGTZ; end
            6'h08, 6'h09: begin fl[DECSETRT] = 1'b1; alu = ALUADD;  end
            6'h0A:        begin fl[DECSETRT] = 1'b1; alu = ALUSLT;  end
            6'h0B:        begin fl[DECSETRT] = 1'b1; alu = ALUSLTU; end
            6'h0C:        begin fl[DECSETRT] = 1'b1; alu = ALUAND;  end
            6'h0D:        begin fl[DECSETRT] = 1'b1; alu = ALUOR;   end
            6'h0E:        begin fl[DECSETRT] = 1'b1; alu = ALUXOR;  end
            6'h0F:        begin fl[DECSETRT] = 1'b1; alu = ALULUI;  end
            6'h20, 6'h21, 6'h23, 6'h37: begin
                fl[DECLOAD]  = 1'b1;
                fl[DECSETRT] = 1'b1;
                alu          = ALUADD;
                sz           = (op == 6'h20) ? SZB : (op == 6'h21) ? SZH :
                               (op == 6'h23) ? SZW : SZD;
            end
            6'h28, 6'h29, 6'h2B, 6'h3F: begin
                fl[DECSTORE] = 1'b1;
                alu          = ALUADD;
                sz           = (op == 6'h28) ? SZB : (op == 6'h29) ? SZH :
                               (op == 6'h2B) ? SZW : SZD;
            end
`ifdef IDEC_QUEUE_FPU_EN
            6'h31, 6'h35: begin
                fl[DECLOAD]  = 1'b1;
                fl[DECSETFT] = 1'b1;
                alu          = ALUADD;
                sz           = op[2] ? SZD : SZW;
            end
            6'h39, 6'h3D: begin
                fl[DECSTORE] = 1'b1;
                fl[DECREGFT] = 1'b1;
                alu          = ALUADD;
                sz           = op[2] ? SZD : SZW;
            end
`endif
            default: fl[DECINVALID] = 1'b1;
        endcase
    end

    assign dec_o = {dec_target(fl, instr_i[15:11], instr_i[20:16]), cond, sz, alu, fl};

endmodule
`default_nettype wire

// File: rtl/idec_queue.sv
`default_nettype none
// ============================================================================
// Module      : idec_queue
// Description : Decoded-instruction queue with delay-slot tagging. Optional
//               FPU decode enabled by defining IDEC_QUEUE_FPU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module idec_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PCW   = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PCW-1:0]           in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DECMAX:0]          out_dec,
    output logic [PCW-1:0]           out_pc,
    output logic                     out_dslot,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DECMAX:0] dec_mem_q [DEPTH];
    logic [PCW-1:0]  pc_mem_q  [DEPTH];
    logic [DEPTH-1:0] ds_mem_q;
    logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0]     count_q, count_d;
    logic            arm_q, arm_d;
    logic [DECMAX:0] push_dec;
    logic            push, pop;

    idec_lane u_lane (
        .instr_i (in_instr),
        .dec_o   (push_dec)
    );

    assign in_ready  = !flush && ((count_q < FULL) || out_ready);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        arm_d   = arm_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            arm_d   = 1'b0;
        end else begin
            if (pop)  rptr_d = rptr_q + AW'(1);
            if (push) begin
                wptr_d = wptr_q + AW'(1);
                arm_d  = push_dec[DECBRANCH];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            arm_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            arm_q   <= arm_d;
        end
    end

    // Storage needs no reset: an empty count masks every stale slot
    always_ff @(posedge clk) begin
        if (push) begin
            dec_mem_q[wptr_q] <= push_dec;
            pc_mem_q[wptr_q]  <= in_pc;
            ds_mem_q[wptr_q]  <= arm_q;
        end
    end

    assign out_dec   = out_valid ? dec_mem_q[rptr_q] : '0;
    assign out_pc    = out_valid ? pc_mem_q[rptr_q]  : '0;
    assign out_dslot = out_valid ? ds_mem_q[rptr_q]  : 1'b0;
    assign count     = count_q;

endmodule
`default_nettype wire
